// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type and counter sizing helpers for button_pulser
package button_pkg;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} btn_state_t;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser whose flops reset to a chosen level
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async input through two flops; reset parks both at RST_VAL
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= {RST_VAL, RST_VAL};
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/button_pulser.sv
// button_pulser: debounced push-button to single-cycle pulse with optional auto-repeat
module button_pulser
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic pulse,
  output logic pressed
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  btn_state_t state, state_d;
  logic [DW-1:0] deb_cnt, deb_d;
  logic [RW-1:0] rep_cnt, rep_d, rep_last;
  logic first_rep, first_d, pulse_d, btn_n, btn_s;
  assign btn_n = ACTIVE_LOW ? ~btn_raw : btn_raw;
  sync2 #(.RST_VAL(1'b0)) u_sync (.clk(clk), .reset(reset), .d(btn_n), .q(btn_s));
  assign rep_last = first_rep ? DELAY_LAST : PERIOD_LAST;
  // next-state logic: press/release debounce and auto-repeat timing
  always_comb begin
    state_d = state;
    deb_d   = deb_cnt;
    rep_d   = rep_cnt;
    first_d = first_rep;
    pulse_d = 1'b0;
    case (state)
      IDLE:
        if (btn_s) begin
          state_d = DEB_PRESS;
          deb_d   = '0;
        end
      DEB_PRESS:
        if (!btn_s) state_d = IDLE;
        else if (deb_cnt == DEB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b1;
        end else deb_d = deb_cnt + 1'b1;
      HELD:
        if (!btn_s) begin
          state_d = DEB_RELEASE;
          deb_d   = '0;
        end else if (!repeat_en) rep_d = '0;
        else if (rep_cnt == rep_last) begin
          pulse_d = 1'b1;
          rep_d   = '0;
          first_d = 1'b0;
        end else rep_d = rep_cnt + 1'b1;
      DEB_RELEASE:
        if (btn_s) begin
          state_d = HELD;
          rep_d   = '0;
        end else if (deb_cnt == DEB_LAST) state_d = IDLE;
        else deb_d = deb_cnt + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      rep_cnt   <= '0;
      first_rep <= 1'b0;
      pulse     <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      state     <= state_d;
      deb_cnt   <= deb_d;
      rep_cnt   <= rep_d;
      first_rep <= first_d;
      pulse     <= pulse_d;
      pressed   <= (state_d == HELD) || (state_d == DEB_RELEASE);
    end
endmodule
